// File: rtl/post_addsub_acc_if.sv
// Operand/result bundle of the post-adder/accumulator: controls and operands in, P-stage results out.
interface post_addsub_acc_if #(
    parameter int WIDTH = 48
);
    logic             ce_in;
    logic             ce_p;
    logic             valid_in;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] c_in;
    logic [WIDTH-1:0] pcin;
    logic [2:0]       opmode;
    logic             cin;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] pcout;
    logic             cout;
    logic             ovf;
    logic             valid_out;

    modport master (
        output ce_in, ce_p, valid_in, x_in, c_in, pcin, opmode, cin,
        input  p, pcout, cout, ovf, valid_out
    );

    modport slave (
        input  ce_in, ce_p, valid_in, x_in, c_in, pcin, opmode, cin,
        output p, pcout, cout, ovf, valid_out
    );
endinterface

// File: rtl/post_addsub_acc.sv
// Pipelined Z +/- (X + cin) post-adder with accumulator feedback, cascade, carry/borrow and signed overflow.
module post_addsub_acc #(
    parameter int WIDTH = 48,
    parameter int INREG = 1
) (
    input logic                clk,
    input logic                rst,
    post_addsub_acc_if.slave   bus
);

    // Exact signed result carries two guard bits; it fits WIDTH bits only if the top three agree.
    function automatic logic signed_ovf(input logic [WIDTH+1:0] v);
        signed_ovf = (v[WIDTH+1] != v[WIDTH]) || (v[WIDTH] != v[WIDTH-1]);
    endfunction

    logic [WIDTH-1:0] x_s;
    logic [WIDTH-1:0] c_s;
    logic [WIDTH-1:0] pcin_s;
    logic [2:0]       opmode_s;
    logic             cin_s;
    logic             valid_s;

    logic [WIDTH-1:0] z_s;
    logic [WIDTH:0]   xc_s;
    logic [WIDTH:0]   r_s;
    logic [WIDTH+1:0] zx_s;
    logic [WIDTH+1:0] xcx_s;
    logic [WIDTH+1:0] exact_s;
    logic             ovf_s;

    logic [WIDTH-1:0] p_r;
    logic             cout_r;
    logic             ovf_r;
    logic             valid_r;

    generate
        if (INREG != 0) begin : g_inreg
            logic [WIDTH-1:0] x_r;
            logic [WIDTH-1:0] c_r;
            logic [WIDTH-1:0] pcin_r;
            logic [2:0]       opmode_r;
            logic             cin_r;
            logic             valid_in_r;

            // Input stage: capture all operands and controls when enabled, clear on reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    x_r        <= {WIDTH{1'b0}};
                    c_r        <= {WIDTH{1'b0}};
                    pcin_r     <= {WIDTH{1'b0}};
                    opmode_r   <= 3'b000;
                    cin_r      <= 1'b0;
                    valid_in_r <= 1'b0;
                end else if (bus.ce_in) begin
                    x_r        <= bus.x_in;
                    c_r        <= bus.c_in;
                    pcin_r     <= bus.pcin;
                    opmode_r   <= bus.opmode;
                    cin_r      <= bus.cin;
                    valid_in_r <= bus.valid_in;
                end
            end

            assign x_s      = x_r;
            assign c_s      = c_r;
            assign pcin_s   = pcin_r;
            assign opmode_s = opmode_r;
            assign cin_s    = cin_r;
            assign valid_s  = valid_in_r;
        end else begin : g_comb
            assign x_s      = bus.x_in;
            assign c_s      = bus.c_in;
            assign pcin_s   = bus.pcin;
            assign opmode_s = bus.opmode;
            assign cin_s    = bus.cin;
            assign valid_s  = bus.valid_in;
        end
    endgenerate

    // Z operand select; accumulate feeds back the registered P only.
    always_comb begin
        z_s = {WIDTH{1'b0}};
        case (opmode_s[1:0])
            2'd0:    z_s = {WIDTH{1'b0}};
            2'd1:    z_s = pcin_s;
            2'd2:    z_s = p_r;
            2'd3:    z_s = c_s;
            default: z_s = {WIDTH{1'b0}};
        endcase
    end

    // Unsigned WIDTH+1 result for P/cout, and sign-extended exact result for overflow.
    always_comb begin
        xc_s    = {1'b0, x_s} + {{WIDTH{1'b0}}, cin_s};
        zx_s    = {{2{z_s[WIDTH-1]}}, z_s};
        xcx_s   = {{2{x_s[WIDTH-1]}}, x_s} + {{(WIDTH+1){1'b0}}, cin_s};
        if (opmode_s[2]) begin
            r_s     = {1'b0, z_s} - xc_s;
            exact_s = zx_s - xcx_s;
        end else begin
            r_s     = {1'b0, z_s} + xc_s;
            exact_s = zx_s + xcx_s;
        end
        ovf_s = signed_ovf(exact_s);
    end

    // P stage: result, carry/borrow, overflow and valid update together when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_r     <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            valid_r <= 1'b0;
        end else if (bus.ce_p) begin
            p_r     <= r_s[WIDTH-1:0];
            cout_r  <= r_s[WIDTH];
            ovf_r   <= ovf_s;
            valid_r <= valid_s;
        end
    end

    assign bus.p         = p_r;
    assign bus.pcout     = p_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign bus.valid_out = valid_r;

endmodule
